// File: rtl/pluto_spi_frame_engine.sv
// SPI mode-0 slave frame engine for the pluto stepgen: shifts a fixed-length byte frame, returns
// a start-of-frame snapshot of pos/din, and commits received settings only from a complete frame.
module pluto_spi_frame_engine #(
   parameter int N_AXES = 4,
   parameter int POS_W  = 21,
   parameter int VEL_W  = 12,
   parameter int T      = 4,
   parameter int DOUT_W = 10,
   parameter int DIN_W  = 16
) (
   input  logic                    clk,
   input  logic                    reset,
   input  logic                    sck,
   input  logic                    ssel,
   input  logic                    mosi,
   output logic                    miso,
   input  logic [N_AXES*POS_W-1:0] pos,
   input  logic [DIN_W-1:0]        din,
   output logic [N_AXES*VEL_W-1:0] vel,
   output logic [DOUT_W-1:0]       dout,
   output logic [T-1:0]            dirtime,
   output logic [T-1:0]            steptime,
   output logic                    step_pol,
   output logic [1:0]              tap,
   output logic                    wdt_kick,
   output logic                    frame_commit,
   output logic                    frame_err,
   output logic                    busy
);
   localparam int FB   = 4 * (N_AXES + 1);
   localparam int FBIT = 8 * FB;
   localparam int BC_W = $clog2(FB + 2);
   localparam int CW   = 32 * N_AXES;  // bit offset of the control word
   localparam logic [BC_W-1:0] FB_C  = BC_W'(FB);
   localparam logic [BC_W-1:0] FB1_C = BC_W'(FB + 1);

   typedef enum logic {S_IDLE, S_FRAME} state_t;

   state_t                  state_q, state_d;
   logic [2:0]              sck_sync_q, sck_sync_d;
   logic [2:0]              ssel_sync_q, ssel_sync_d;
   logic [BC_W-1:0]         byte_cnt_q, byte_cnt_d;
   logic [2:0]              bit_cnt_q, bit_cnt_d;
   logic                    load_pend_q, load_pend_d;
   logic [6:0]              rx_q, rx_d;
   logic [7:0]              tx_q, tx_d;
   logic [FBIT-1:0]         snap_q, snap_d;
   logic [FBIT-1:0]         shadow_q, shadow_d;
   logic [N_AXES*VEL_W-1:0] vel_q, vel_d;
   logic [DOUT_W-1:0]       dout_q, dout_d;
   logic [T-1:0]            dirtime_q, dirtime_d;
   logic [T-1:0]            steptime_q, steptime_d;
   logic                    step_pol_q, step_pol_d;
   logic [1:0]              tap_q, tap_d;
   logic                    wdt_kick_q, wdt_kick_d;
   logic                    frame_commit_q, frame_commit_d;
   logic                    frame_err_q, frame_err_d;
   logic [7:0]              frame_cnt_q, frame_cnt_d;
   logic [7:0]              err_cnt_q, err_cnt_d;

   logic                    sck_rise, sck_fall, ssel_rise, ssel_fall;
   logic [FBIT-1:0]         snap_now;
   logic [BC_W-1:0]         rd_idx;
   logic                    unused_shadow;

   // Synchronisers reset to 0, so a falling ssel edge can only be seen after ssel was sampled high.
   assign sck_rise  =  sck_sync_q[1]  & ~sck_sync_q[2];
   assign sck_fall  = ~sck_sync_q[1]  &  sck_sync_q[2];
   assign ssel_rise =  ssel_sync_q[1] & ~ssel_sync_q[2];
   assign ssel_fall = ~ssel_sync_q[1] &  ssel_sync_q[2];

   // Reserved and out-of-width frame fields are received but never drive an output.
   assign unused_shadow = ^shadow_q;

   always_comb begin
      snap_now = '0;
      for (int k = 0; k < N_AXES; k++) begin
         snap_now[k*32 +: 32] = 32'(pos[k*POS_W +: POS_W]);
      end
      snap_now[CW +: 32] = {err_cnt_q, frame_cnt_q, 16'(din)};
      rd_idx = (byte_cnt_q < FB_C) ? byte_cnt_q : '0;
   end

   always_comb begin
      sck_sync_d     = {sck_sync_q[1:0], sck};
      ssel_sync_d    = {ssel_sync_q[1:0], ssel};
      state_d        = state_q;
      byte_cnt_d     = byte_cnt_q;
      bit_cnt_d      = bit_cnt_q;
      load_pend_d    = load_pend_q;
      rx_d           = rx_q;
      tx_d           = tx_q;
      snap_d         = snap_q;
      shadow_d       = shadow_q;
      vel_d          = vel_q;
      dout_d         = dout_q;
      dirtime_d      = dirtime_q;
      steptime_d     = steptime_q;
      step_pol_d     = step_pol_q;
      tap_d          = tap_q;
      frame_cnt_d    = frame_cnt_q;
      err_cnt_d      = err_cnt_q;
      wdt_kick_d     = 1'b0;
      frame_commit_d = 1'b0;
      frame_err_d    = 1'b0;

      case (state_q)
         S_IDLE: begin
            if (ssel_fall) begin
               state_d     = S_FRAME;
               snap_d      = snap_now;
               byte_cnt_d  = '0;
               bit_cnt_d   = '0;
               load_pend_d = 1'b0;
               tx_d        = snap_now[7:0];
            end
         end
         S_FRAME: begin
            if (ssel_rise) begin
               state_d = S_IDLE;
               if (byte_cnt_q == FB_C && bit_cnt_q == 3'd0) begin
                  for (int k = 0; k < N_AXES; k++) begin
                     vel_d[k*VEL_W +: VEL_W] = shadow_q[k*32 +: VEL_W];
                  end
                  dout_d         = shadow_q[CW +: DOUT_W];
                  dirtime_d      = shadow_q[CW+16 +: T];
                  step_pol_d     = shadow_q[CW+23];
                  steptime_d     = shadow_q[CW+24 +: T];
                  wdt_kick_d     = shadow_q[CW+29];
                  tap_d          = shadow_q[CW+30 +: 2];
                  frame_commit_d = 1'b1;
                  frame_cnt_d    = frame_cnt_q + 8'd1;
               end else begin
                  frame_err_d = 1'b1;
                  if (err_cnt_q != 8'hFF) err_cnt_d = err_cnt_q + 8'd1;
               end
            end else if (sck_rise) begin
               rx_d      = {rx_q[5:0], mosi};
               bit_cnt_d = bit_cnt_q + 3'd1;
               if (bit_cnt_q == 3'd7) begin
                  if (byte_cnt_q < FB_C) shadow_d[{byte_cnt_q, 3'b000} +: 8] = {rx_q, mosi};
                  if (byte_cnt_q != FB1_C) byte_cnt_d = byte_cnt_q + BC_W'(1);
                  load_pend_d = 1'b1;
               end
            end else if (sck_fall) begin
               // byte_cnt already points at the next byte when a reload is pending
               if (load_pend_q) begin
                  tx_d        = (byte_cnt_q < FB_C) ? snap_q[{rd_idx, 3'b000} +: 8] : 8'h00;
                  load_pend_d = 1'b0;
               end else begin
                  tx_d = {tx_q[6:0], 1'b0};
               end
            end
         end
         default: state_d = S_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q        <= S_IDLE;
         sck_sync_q     <= '0;
         ssel_sync_q    <= '0;
         byte_cnt_q     <= '0;
         bit_cnt_q      <= '0;
         load_pend_q    <= 1'b0;
         rx_q           <= '0;
         tx_q           <= '0;
         snap_q         <= '0;
         shadow_q       <= '0;
         vel_q          <= '0;
         dout_q         <= '0;
         dirtime_q      <= '0;
         steptime_q     <= '0;
         step_pol_q     <= 1'b0;
         tap_q          <= '0;
         wdt_kick_q     <= 1'b0;
         frame_commit_q <= 1'b0;
         frame_err_q    <= 1'b0;
         frame_cnt_q    <= '0;
         err_cnt_q      <= '0;
      end else begin
         state_q        <= state_d;
         sck_sync_q     <= sck_sync_d;
         ssel_sync_q    <= ssel_sync_d;
         byte_cnt_q     <= byte_cnt_d;
         bit_cnt_q      <= bit_cnt_d;
         load_pend_q    <= load_pend_d;
         rx_q           <= rx_d;
         tx_q           <= tx_d;
         snap_q         <= snap_d;
         shadow_q       <= shadow_d;
         vel_q          <= vel_d;
         dout_q         <= dout_d;
         dirtime_q      <= dirtime_d;
         steptime_q     <= steptime_d;
         step_pol_q     <= step_pol_d;
         tap_q          <= tap_d;
         wdt_kick_q     <= wdt_kick_d;
         frame_commit_q <= frame_commit_d;
         frame_err_q    <= frame_err_d;
         frame_cnt_q    <= frame_cnt_d;
         err_cnt_q      <= err_cnt_d;
      end
   end

   assign miso         = tx_q[7];
   assign busy         = (state_q == S_FRAME);
   assign vel          = vel_q;
   assign dout         = dout_q;
   assign dirtime      = dirtime_q;
   assign steptime     = steptime_q;
   assign step_pol     = step_pol_q;
   assign tap          = tap_q;
   assign wdt_kick     = wdt_kick_q;
   assign frame_commit = frame_commit_q;
   assign frame_err    = frame_err_q;
endmodule
